keypad_code_entry: RTL and testbench
====================================

Name: keypad_code_entry

Overview:
- Keypad front end that produces the single-cycle arm/disarm strobes consumed by the home security controller.
- Collects digit key events and compares them against a stored passcode. A correct code followed by a command key issues the strobe.
- Bounds entry time and locks the keypad out after repeated wrong codes.

Parameters:
- CODE_LEN, 4, number of digits in the passcode
- DEFAULT_CODE, 16'h1234, passcode loaded at reset (CODE_LEN BCD digits, MSD first)
- TIMEOUT_CYC, 1000, idle cycles in ENTRY before the buffer is abandoned
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout
- LOCKOUT_CYC, 5000, cycles the keypad ignores keys once locked
- CNT_W, 16, width of the shared timer counter; must hold max(TIMEOUT_CYC, LOCKOUT_CYC)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle
- key_code  in  4  0x0-0x9 digit, 0xA ARM, 0xB DISARM, 0xC CLEAR, 0xD-0xF ignored
- code_load  in  1  load new passcode from code_in
- code_in  in  4*CODE_LEN  new passcode, BCD, MSD first
- arm  out  1  one-cycle arm strobe
- disarm  out  1  one-cycle disarm strobe
- bad_code  out  1  one-cycle strobe on a rejected command
- locked  out  1  high throughout LOCKOUT
- digit_cnt  out  3  digits buffered, saturating at CODE_LEN+1

Behaviour:
- Reset: state IDLE; arm, disarm, bad_code, locked = 0; digit_cnt = 0; fail_cnt = 0; timer = 0; stored code = DEFAULT_CODE.
- All outputs are registered. A strobe appears the cycle after the key_valid that caused it.
- IDLE:
  - Digit key: shift the digit in, set digit_cnt = 1, load timer = TIMEOUT_CYC, go to ENTRY.
  - ARM, DISARM or CLEAR key: no effect, no bad_code.
- ENTRY:
  - Digit key: shift into the buffer, increment digit_cnt (saturates at CODE_LEN+1, which marks overflow), reload timer.
  - CLEAR key: empty the buffer, digit_cnt = 0, go to IDLE. fail_cnt is unchanged.
  - ARM/DISARM key with digit_cnt == CODE_LEN and buffer == stored code: pulse arm or disarm, clear fail_cnt, empty the buffer, go to IDLE.
  - ARM/DISARM key with any other digit count or a mismatch: pulse bad_code, increment fail_cnt, empty the buffer.
    - If fail_cnt reaches MAX_FAIL: go to LOCKOUT, load timer = LOCKOUT_CYC, fail_cnt = 0.
    - Otherwise go to IDLE.
  - Timer reaches 0 with no key: empty the buffer, go to IDLE. Not counted as a failure.
- LOCKOUT:
  - locked = 1 and every key is ignored.
  - The timer decrements each cycle. When it reaches 0, go to IDLE and drop locked the next cycle.
- Simultaneous events:
  - Key arriving in the same cycle as timer expiry: the key wins. It is processed and the timer is reloaded.
  - code_load is accepted only in IDLE with key_valid = 0. Otherwise it is ignored. It has no other side effects.
- Reset mid-operation: asserting reset_n = 0 in any state returns everything to reset values immediately. Any strobe in flight is dropped.
- arm, disarm and bad_code are mutually exclusive; at most one is high in any cycle.

Optional Feature:
- Macro: KEYPAD_DURESS_EN.
- When defined:
  - A duress code (stored code with its last digit incremented mod 10) followed by DISARM pulses disarm as normal.
  - It also sets output duress (1 bit, sticky) until reset. Reset value 0.
  - The duress code followed by ARM is treated as a mismatch.
- When undefined: the duress port and logic are absent, and the duress code is simply a mismatch.

Decomposition:
- home_security_pkg holds:
  - key encodings KEY_ARM, KEY_DISARM, KEY_CLEAR
  - the state encoding IDLE/ENTRY/LOCKOUT as 2-bit localparams
  - the digit width constant DIGIT_W = 4
- One sub-module, keypad_timer: a loadable CNT_W down-counter with load, load_val and a zero flag. It is shared for both the entry timeout and the lockout.

Test Plan:
- Keys 1,2,3,4,ARM -> arm = 1 for exactly one cycle, one cycle after the ARM key; then keys 1,2,3,4,DISARM -> disarm strobe; fail_cnt = 0.
- Keys 1,2,3,5,ARM three times -> bad_code pulses three times; locked rises after the third; keys during 5000 cycles are ignored; locked falls at cycle 5001.
- Keys 1,2 then 1000 idle cycles -> back to IDLE with digit_cnt = 0; then 1,2,3,4,ARM -> arm strobe.
- Keys 1,2,3,4,4,ARM -> digit_cnt shows 5, bad_code pulses; keys 1,2,CLEAR,1,2,3,4,DISARM -> disarm strobe.
- code_load with 16'h9876 in IDLE; then 1,2,3,4,ARM -> bad_code; then 9,8,7,6,ARM -> arm; reset_n pulse -> code is 1234 again.
- With KEYPAD_DURESS_EN: keys 1,2,3,5,DISARM -> disarm and duress = 1 held; keys 1,2,3,5,ARM -> bad_code.

Source files
------------

// File: rtl/home_security_pkg.sv
// Shared key encodings, FSM state encoding and BCD helpers for the keypad front end.
package home_security_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] KEY_ARM    = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_DISARM = 4'hB;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR  = 4'hC;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ENTRY   = 2'd1;
    localparam logic [1:0] LOCKOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ENTRY   = ENTRY,
        ST_LOCKOUT = LOCKOUT
    } state_e;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_timer.sv
// Loadable down-counter with zero flag; shared by the entry timeout and the lockout hold.
module keypad_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad passcode entry producing arm/disarm/bad_code strobes with timeout and lockout.
// Optional duress disarm code is enabled by defining KEYPAD_DURESS_EN.
module keypad_code_entry
    import home_security_pkg::*;
#(
    parameter int                      CODE_LEN     = 4,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                      TIMEOUT_CYC  = 1000,
    parameter int                      MAX_FAIL     = 3,
    parameter int                      LOCKOUT_CYC  = 5000,
    parameter int                      CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  code_load,
    input  logic [4*CODE_LEN-1:0] code_in,
    output logic                  arm,
    output logic                  disarm,
    output logic                  bad_code,
    output logic                  locked,
`ifdef KEYPAD_DURESS_EN
    output logic                  duress,
`endif
    output logic [2:0]            digit_cnt
);

    localparam int         CODE_W   = DIGIT_W * CODE_LEN;
    localparam int         FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [2:0] CNT_FULL = 3'(CODE_LEN);
    localparam logic [2:0] CNT_OVF  = 3'(CODE_LEN + 1);

    state_e              state_r, state_s;
    logic [CODE_W-1:0]   code_r, code_s;
    logic [CODE_W-1:0]   buf_r, buf_s;
    logic [2:0]          cnt_r, cnt_s;
    logic [FAIL_W-1:0]   fail_r, fail_s;
    logic                arm_r, arm_s, disarm_r, disarm_s, bad_r, bad_s, locked_r;
    logic                tload_s, timer_zero_s, code_ok_s, accept_s, is_cmd_s;
    logic [CNT_W-1:0]    tval_s;

    keypad_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tload_s),
        .load_val (tval_s),
        .zero     (timer_zero_s)
    );

    assign code_ok_s = (cnt_r == CNT_FULL) && (buf_r == code_r);
    assign is_cmd_s  = (key_code == KEY_ARM) || (key_code == KEY_DISARM);

`ifdef KEYPAD_DURESS_EN
    logic duress_r, duress_s, duress_hit_s;
    // duress code is the stored code with its last digit bumped mod 10, disarm only
    assign duress_hit_s = !code_ok_s && (key_code == KEY_DISARM) && (cnt_r == CNT_FULL) &&
                          (buf_r == {code_r[CODE_W-1:DIGIT_W], bcd_inc(code_r[DIGIT_W-1:0])});
    assign accept_s = code_ok_s || duress_hit_s;
    assign duress   = duress_r;
`else
    assign accept_s = code_ok_s;
`endif

    // next-state and next-output logic
    always_comb begin
        state_s  = state_r;
        code_s   = code_r;
        buf_s    = buf_r;
        cnt_s    = cnt_r;
        fail_s   = fail_r;
        arm_s    = 1'b0;
        disarm_s = 1'b0;
        bad_s    = 1'b0;
        tload_s  = 1'b0;
        tval_s   = CNT_W'(TIMEOUT_CYC);
`ifdef KEYPAD_DURESS_EN
        duress_s = duress_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    buf_s   = {buf_r[CODE_W-DIGIT_W-1:0], key_code};
                    cnt_s   = 3'd1;
                    tload_s = 1'b1;
                    state_s = ST_ENTRY;
                end else if (!key_valid && code_load) begin
                    code_s = code_in;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (key_valid && is_digit(key_code)) begin
                    buf_s   = {buf_r[CODE_W-DIGIT_W-1:0], key_code};
                    cnt_s   = (cnt_r >= CNT_OVF) ? CNT_OVF : cnt_r + 3'd1;
                    tload_s = 1'b1;
                end else if (key_valid && (key_code == KEY_CLEAR)) begin
                    buf_s   = {CODE_W{1'b0}};
                    cnt_s   = 3'd0;
                    state_s = ST_IDLE;
                end else if (key_valid && is_cmd_s) begin
                    buf_s   = {CODE_W{1'b0}};
                    cnt_s   = 3'd0;
                    state_s = ST_IDLE;
                    if (accept_s) begin
                        arm_s    = (key_code == KEY_ARM);
                        disarm_s = (key_code == KEY_DISARM);
                        fail_s   = {FAIL_W{1'b0}};
`ifdef KEYPAD_DURESS_EN
                        duress_s = duress_r | duress_hit_s;
`endif
                    end else begin
                        bad_s = 1'b1;
                        if (fail_r == FAIL_W'(MAX_FAIL - 1)) begin
                            fail_s  = {FAIL_W{1'b0}};
                            tload_s = 1'b1;
                            tval_s  = CNT_W'(LOCKOUT_CYC);
                            state_s = ST_LOCKOUT;
                        end else begin
                            fail_s = fail_r + FAIL_W'(1);
                        end
                    end
                end else if (timer_zero_s) begin
                    // abandoned entry; not counted as a failure
                    buf_s   = {CODE_W{1'b0}};
                    cnt_s   = 3'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCKOUT;
                end
            end
            default: begin
                buf_s   = {CODE_W{1'b0}};
                cnt_s   = 3'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // state, stored code and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            code_r   <= DEFAULT_CODE;
            buf_r    <= {CODE_W{1'b0}};
            cnt_r    <= 3'd0;
            fail_r   <= {FAIL_W{1'b0}};
            arm_r    <= 1'b0;
            disarm_r <= 1'b0;
            bad_r    <= 1'b0;
            locked_r <= 1'b0;
`ifdef KEYPAD_DURESS_EN
            duress_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            code_r   <= code_s;
            buf_r    <= buf_s;
            cnt_r    <= cnt_s;
            fail_r   <= fail_s;
            arm_r    <= arm_s;
            disarm_r <= disarm_s;
            bad_r    <= bad_s;
            locked_r <= (state_s == ST_LOCKOUT);
`ifdef KEYPAD_DURESS_EN
            duress_r <= duress_s;
`endif
        end
    end

    assign arm       = arm_r;
    assign disarm    = disarm_r;
    assign bad_code  = bad_r;
    assign locked    = locked_r;
    assign digit_cnt = cnt_r;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboard bench for keypad_code_entry: directed scenarios plus random keys against a behavioural model.
`timescale 1ns/1ps
module tb_keypad_code_entry;

    localparam int TIMEOUT  = 1000;
    localparam int LOCKOUT  = 5000;
    localparam int MAX_FAIL = 3;

    logic        clk = 1'b0, reset_n = 1'b0, key_valid = 1'b0, code_load = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] code_in = 16'h0000;
    logic        arm, disarm, bad_code, locked;
    logic [2:0]  digit_cnt;
`ifdef KEYPAD_DURESS_EN
    logic        duress;
`endif

    keypad_code_entry #(
        .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .TIMEOUT_CYC(TIMEOUT),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .code_load(code_load), .code_in(code_in), .arm(arm), .disarm(disarm),
        .bad_code(bad_code), .locked(locked),
`ifdef KEYPAD_DURESS_EN
        .duress(duress),
`endif
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int kind; longint at; bit dur; } exp_t;   // kind 1=arm 2=disarm 3=bad
    exp_t expq[$];

    // behavioural model: entered value, digit count, deadlines expressed in cycles
    logic [15:0] m_code, m_buf;
    int          m_cnt, m_fail;
    bit          m_entry, m_duress;
    longint      m_last, m_lock;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_code = 16'h1234; m_buf = 16'h0000; m_cnt = 0; m_fail = 0;
        m_entry = 1'b0; m_duress = 1'b0; m_last = 0; m_lock = -1000000;
        expq.delete();
    endfunction

    // a lockout triggered by a key at cycle t holds for cycles t+1 .. t+LOCKOUT+1
    function automatic bit m_locked(longint t);
        return (t >= m_lock + 1) && (t <= m_lock + LOCKOUT + 1);
    endfunction

    // an entry opened by a digit at cycle t survives a key arriving up to t+TIMEOUT+1
    function automatic void m_refresh(longint t);
        if (m_entry && (t - m_last >= TIMEOUT + 2)) begin
            m_entry = 1'b0; m_cnt = 0; m_buf = 16'h0000;
        end
    endfunction

    function automatic void m_key(int k, longint t);
        bit ok, dur;
        logic [15:0] dc;
        if (m_locked(t)) return;
        m_refresh(t);
        if (k <= 9) begin
            m_buf   = (m_buf << 4) | 16'(k);
            m_cnt   = (m_cnt >= 5) ? 5 : m_cnt + 1;
            m_entry = 1'b1;
            m_last  = t;
        end else if (m_entry && k == 12) begin
            m_entry = 1'b0; m_cnt = 0; m_buf = 16'h0000;
        end else if (m_entry && (k == 10 || k == 11)) begin
            ok  = (m_cnt == 4) && (m_buf == m_code);
            dur = 1'b0;
            dc  = {m_code[15:4], 4'((int'(m_code[3:0]) + 1) % 10)};
`ifdef KEYPAD_DURESS_EN
            if (!ok && k == 11 && m_cnt == 4 && m_buf == dc) begin ok = 1'b1; dur = 1'b1; end
`endif
            if (ok) begin
                m_fail = 0;
                if (dur) m_duress = 1'b1;
                expq.push_back('{(k == 10) ? 1 : 2, t + 1, m_duress});
            end else begin
                expq.push_back('{3, t + 1, m_duress});
                m_fail++;
                if (m_fail == MAX_FAIL) begin m_fail = 0; m_lock = t; end
            end
            m_entry = 1'b0; m_cnt = 0; m_buf = 16'h0000;
        end
    endfunction

    function automatic void m_load(logic [15:0] val, bit v, longint t);
        if (!v && !m_locked(t)) begin
            m_refresh(t);
            if (!m_entry) m_code = val;
        end
    endfunction

    // monitor: pops the scoreboard on every strobe and tracks the locked level
    always @(negedge clk) begin
        int   n, kind;
        exp_t e;
        if (reset_n) begin
            n = int'(arm) + int'(disarm) + int'(bad_code);
            if (n > 1) chk("strobe_exclusive", n, 1);
            if (n > 0) begin
                kind = arm ? 1 : (disarm ? 2 : 3);
                if (expq.size() == 0) begin
                    chk("unexpected_strobe", kind, 0);
                end else begin
                    e = expq.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    chk("strobe_cycle", cyc, e.at);
`ifdef KEYPAD_DURESS_EN
                    chk("duress", duress, e.dur);
`endif
                end
            end
            chk("locked", locked, m_locked(cyc));
        end
    end

    task automatic drive(bit v, int k, bit ld, logic [15:0] val, int gap);
        key_valid = v; key_code = 4'(k); code_load = ld; code_in = val;
        if (ld) m_load(val, v, cyc);
        if (v) m_key(k, cyc);
        @(negedge clk);
        key_valid = 1'b0; code_load = 1'b0;
        m_refresh(cyc);
        chk("digit_cnt", digit_cnt, m_cnt);
        repeat (gap) @(negedge clk);
    endtask

    task automatic key(int k);
        drive(1'b1, k, 1'b0, 16'h0000, 1);
    endtask

    task automatic code_seq(logic [15:0] c, int cmd);
        for (int i = 3; i >= 0; i--) key(int'(c[i*4 +: 4]));
        key(cmd);
    endtask

    task automatic wait_until(longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_arm", arm, 0);
        chk("rst_disarm", disarm, 0);
        chk("rst_bad", bad_code, 0);
        chk("rst_locked", locked, 0);
        chk("rst_cnt", digit_cnt, 0);
`ifdef KEYPAD_DURESS_EN
        chk("rst_duress", duress, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint lim;
        logic [15:0] rc;
        int r;
        m_reset();
        do_reset();

        // arm then disarm with the default code; duress probe
        code_seq(16'h1234, 10);
        code_seq(16'h1234, 11);
        code_seq(16'h1235, 11);
        code_seq(16'h1234, 10);

        // three wrong codes -> lockout; keys during lockout ignored
        repeat (3) code_seq(16'h1235, 10);
        lim = m_lock + LOCKOUT + 1;
        repeat (20) drive(1'b1, $urandom_range(0, 15), 1'b0, 16'h0000, $urandom_range(50, 200));
        drive(1'b0, 0, 1'b1, 16'h5555, 1);
        wait_until(lim);
        key(1);
        code_seq(16'h1234, 10);

        // entry timeout boundary: key one cycle before expiry still counts
        key(1); key(2);
        wait_until(m_last + TIMEOUT + 1);
        m_refresh(cyc); chk("cnt_before_timeout", digit_cnt, m_cnt);
        @(negedge clk);
        m_refresh(cyc); chk("cnt_after_timeout", digit_cnt, m_cnt);
        key(1); key(2); key(3);
        wait_until(m_last + TIMEOUT + 1);
        key(4); key(10);

        // overflow, then clear and disarm
        key(1); key(2); key(3); key(4); key(4); key(10);
        key(1); key(2); key(12); code_seq(16'h1234, 11);

        // code load, ignored load with a key, reset restores default
        drive(1'b0, 0, 1'b1, 16'h9876, 1);
        code_seq(16'h1234, 10);
        code_seq(16'h9876, 10);
        drive(1'b1, 3, 1'b1, 16'h5555, 1);
        key(12);
        code_seq(16'h5555, 10);
        do_reset();
        code_seq(16'h1234, 10);

        // random traffic
        for (int it = 0; it < 200 && cyc < 70000; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                code_seq(m_code, $urandom_range(10, 11));
            end else if (r < 4) begin
                rc = m_code;
                rc[3:0] = 4'((int'(rc[3:0]) + $urandom_range(1, 2)) % 10);
                code_seq(rc, $urandom_range(10, 11));
            end else if (r < 5) begin
                for (int i = 0; i < 4; i++) rc[i*4 +: 4] = 4'($urandom_range(0, 9));
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 15), 1'b1, rc, $urandom_range(0, 3));
            end else if (r < 6 && $urandom_range(0, 9) == 0) begin
                key(1);
                repeat (TIMEOUT + 10) @(negedge clk);
            end else begin
                drive(1'b1, ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
                      1'b0, 16'h0000, $urandom_range(0, 3));
            end
            if (m_locked(cyc)) wait_until(m_lock + LOCKOUT + 3);
        end

        repeat (5) @(negedge clk);
        chk("pending_strobes", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
